// File: rtl/lab_pkg.sv
// lab_pkg: shared FSM state type and default operand width for the serial adder.
package lab_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/fa_bit.sv
// fa_bit: combinational one-bit full adder.
// Ports: x, y, ci - addend bits and carry-in; s - sum bit; co - carry-out.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one bit pair per clock LSB first through a single fa_bit.
// Ports: clk, rst_n (async active-low); start/a/b/cin captured in IDLE;
//        busy high while adding; done one-cycle pulse; sum/cout registered, held until next completion.
module serial_adder_ctrl
    import lab_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, acc_q, acc_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_bit, c_bit;

    fa_bit u_fa (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start) begin
                a_sr_d  = a;
                b_sr_d  = b;
                carry_d = cin;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                // new sum bit enters at the MSB so the LSB-first stream lands in order
                acc_d   = WIDTH'({s_bit, acc_q} >> 1);
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = c_bit;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
